// File: rtl/shift3d_pkg.sv
// Shared constants, state type and sizing helper for the packed 3-D shift frame controller.
package shift3d_pkg;

    localparam int SHIFT3D_A = 3;
    localparam int SHIFT3D_B = 5;
    localparam int SHIFT3D_C = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } shift3d_state_t;

    // Bits needed to hold a count of 0..n inclusive.
    function automatic int shift3d_count_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift3d_array.sv
// Packed [A-1:0][B-1:0][C-1:0] serial shift storage; each shift moves every bit one flattened
// index up and loads in_bit at [0][0][0].
module shift3d_array #(
    parameter int A = 3,
    parameter int B = 5,
    parameter int C = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       shift_en,
    input  logic                       in_bit,
    output logic [A-1:0][B-1:0][C-1:0] out
);

    localparam int N = A * B * C;

    // Flattened index i*B*C + j*C + k walks [i][j][0] -> [i][j][1] -> [i][j+1][0] -> ... -> [i+1][0][0].
    logic [N-1:0] flat;

    generate
        if (N == 1) begin : g_single
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    flat <= '0;
                end else if (shift_en) begin
                    flat <= in_bit;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    flat <= '0;
                end else if (shift_en) begin
                    flat <= {flat[N-2:0], in_bit};
                end
            end
        end
    endgenerate

    assign out = flat;

endmodule

// File: rtl/shift3d_frame_ctrl.sv
// Serial-in / frame-out sequencer for the packed 3-D shift array.
// Optional SHIFT3D_FRAME_PARITY_EN adds frame_parity, the XOR of the held frame.
module shift3d_frame_ctrl
    import shift3d_pkg::*;
#(
    parameter int A = SHIFT3D_A,
    parameter int B = SHIFT3D_B,
    parameter int C = SHIFT3D_C
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic                       in_bit,
    output logic                       in_ready,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic [A-1:0][B-1:0][C-1:0] frame_out,
`ifdef SHIFT3D_FRAME_PARITY_EN
    output logic                       frame_parity,
`endif
    output logic                       busy
);

    localparam int N  = A * B * C;
    localparam int CW = shift3d_count_w(N);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid and its payload hold until that edge, and ready never depends on valid.
    // flush cancels any transfer scheduled for the same edge.
    shift3d_state_t state;
    logic [CW-1:0]  count;
    logic           parity;
    logic           accept;
    logic           take;

    assign accept = in_valid && in_ready && !flush;
    assign take   = frame_valid && frame_ready && !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            in_ready    <= 1'b0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            parity      <= 1'b0;
        end else if (flush) begin
            state       <= IDLE;
            count       <= '0;
            in_ready    <= 1'b1;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            parity      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        count  <= ONE;
                        parity <= in_bit;
                        busy   <= 1'b1;
                        if (N == 1) begin
                            state       <= FULL;
                            in_ready    <= 1'b0;
                            frame_valid <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        count  <= count + ONE;
                        parity <= parity ^ in_bit;
                        if (count == LAST) begin
                            state       <= FULL;
                            in_ready    <= 1'b0;
                            frame_valid <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    // No bypass: ready returns only on the edge after the frame is taken.
                    if (take) begin
                        state       <= IDLE;
                        count       <= '0;
                        in_ready    <= 1'b1;
                        frame_valid <= 1'b0;
                        busy        <= 1'b0;
                        parity      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    count       <= '0;
                    in_ready    <= 1'b1;
                    frame_valid <= 1'b0;
                    busy        <= 1'b0;
                    parity      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHIFT3D_FRAME_PARITY_EN
    assign frame_parity = parity;
`endif

    shift3d_array #(
        .A(A),
        .B(B),
        .C(C)
    ) u_array (
        .clock   (clock),
        .reset   (reset),
        .shift_en(accept),
        .in_bit  (in_bit),
        .out     (frame_out)
    );

endmodule

// File: tb/tb_shift3d_frame_ctrl.sv
// Directed and scoreboarded bench for shift3d_frame_ctrl at default dimensions (3x5x2).
module tb_shift3d_frame_ctrl;
  import shift3d_pkg::*;

  localparam int N = SHIFT3D_A * SHIFT3D_B * SHIFT3D_C;
  localparam logic [N-1:0] MASK = {N{1'b1}};

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic in_ready;
  logic frame_valid;
  logic frame_ready = 1'b0;
  logic [SHIFT3D_A-1:0][SHIFT3D_B-1:0][SHIFT3D_C-1:0] frame_out;
  logic busy;
`ifdef SHIFT3D_FRAME_PARITY_EN
  logic frame_parity;
`endif

  int checks = 0;
  int errors = 0;

  shift3d_frame_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_out  (frame_out),
`ifdef SHIFT3D_FRAME_PARITY_EN
    .frame_parity(frame_parity),
`endif
    .busy       (busy)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [N-1:0] bits;      // streamed MSB first
    logic [N-1:0] exp_frame;
    logic         exp_par;
  } vec_t;

  vec_t vecs[6];
  logic [N-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int max_gap);
    int n;
    n = 0;
    repeat ($urandom_range(0, max_gap)) begin
      in_valid = 1'b0;
      in_bit = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    in_valid = 1'b1;
    in_bit = b;
    while (!in_ready && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL in_ready_wait: got 0 want 1 within 200 cycles");
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_bit = 1'($urandom_range(0, 1));
  endtask

  task automatic stream_frame(input logic [N-1:0] v, input int max_gap);
    for (int i = N - 1; i >= 0; i--) begin
      send_bit(v[i], max_gap);
      if (i == 1) check("fv_before_last", 64'(frame_valid), 64'd0);
    end
  endtask

  task automatic take_frame(input int max_stall);
    int n;
    n = 0;
    repeat ($urandom_range(0, max_stall)) begin
      in_valid = 1'b1;
      in_bit = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    while (!frame_valid && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL frame_valid_wait: got 0 want 1 within 200 cycles");
    end
    frame_ready = 1'b1;
    @(posedge clock); #1;
    frame_ready = 1'b0;
  endtask

  initial begin
    logic [N-1:0] prev;
    logic [N-1:0] v;
    logic [N-1:0] got;

    vecs[0] = '{"all_ones",    30'h3FFF_FFFF, 30'h3FFF_FFFF, 1'b0};
    vecs[1] = '{"first_one",   30'h2000_0000, 30'h2000_0000, 1'b1};
    vecs[2] = '{"all_zeros",   30'h0000_0000, 30'h0000_0000, 1'b0};
    vecs[3] = '{"last_one",    30'h0000_0001, 30'h0000_0001, 1'b1};
    vecs[4] = '{"alt_10",      30'h2AAA_AAAA, 30'h2AAA_AAAA, 1'b1};
    vecs[5] = '{"low_three",   30'h0000_0007, 30'h0000_0007, 1'b1};

    // reset
    #1 reset = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_frame_valid", 64'(frame_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_out", 64'(frame_out), 64'd0);
`ifdef SHIFT3D_FRAME_PARITY_EN
    check("rst_parity", 64'(frame_parity), 64'd0);
`endif
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    check("in_ready_held_after_release", 64'(in_ready), 64'd0);
    @(posedge clock); #1;
    check("in_ready_rises", 64'(in_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);

    // table-driven frames
    for (int t = 0; t < 6; t++) begin
      stream_frame(vecs[t].bits, 0);
      check({vecs[t].name, "_fv"}, 64'(frame_valid), 64'd1);
      check({vecs[t].name, "_in_ready"}, 64'(in_ready), 64'd0);
      check({vecs[t].name, "_busy"}, 64'(busy), 64'd1);
      check({vecs[t].name, "_frame"}, 64'(frame_out), 64'(vecs[t].exp_frame));
`ifdef SHIFT3D_FRAME_PARITY_EN
      check({vecs[t].name, "_parity"}, 64'(frame_parity), 64'(vecs[t].exp_par));
`endif
      take_frame(0);
      check({vecs[t].name, "_fv_after_take"}, 64'(frame_valid), 64'd0);
      check({vecs[t].name, "_ready_after_take"}, 64'(in_ready), 64'd1);
      check({vecs[t].name, "_frame_kept"}, 64'(frame_out), 64'(vecs[t].exp_frame));
    end

    // hold in FULL for 5 cycles with bits offered, handshake on cycle 6
    stream_frame(30'h1234_5678, 0);
    in_valid = 1'b1;
    in_bit = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      check("hold_frame", 64'(frame_out), 64'h1234_5678);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_fv", 64'(frame_valid), 64'd1);
    end
    frame_ready = 1'b1;
    @(posedge clock); #1;
    frame_ready = 1'b0;
    in_valid = 1'b0;
    check("hold_release_ready", 64'(in_ready), 64'd1);
    check("hold_release_fv", 64'(frame_valid), 64'd0);
    check("hold_release_frame", 64'(frame_out), 64'h1234_5678);

    // flush mid-fill, with a bit offered on the flush edge
    prev = 30'h1234_5678;
    for (int k = 0; k < 12; k++) send_bit(1'b1, 0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_bit = 1'b0;
    @(posedge clock); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_fv", 64'(frame_valid), 64'd0);
    check("flush_frame_kept", 64'(frame_out), 64'(((prev << 12) | 30'hFFF) & MASK));
    stream_frame(30'h1555_5555, 0);
    check("post_flush_fv", 64'(frame_valid), 64'd1);
    check("post_flush_frame", 64'(frame_out), 64'h1555_5555);
    check("post_flush_first_bit", 64'(frame_out[2][4][1]), 64'd0);
    check("post_flush_last_bit", 64'(frame_out[0][0][0]), 64'd1);
`ifdef SHIFT3D_FRAME_PARITY_EN
    check("post_flush_parity", 64'(frame_parity), 64'd1);
`endif

    // flush while FULL beats a simultaneous frame handshake
    flush = 1'b1;
    frame_ready = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    frame_ready = 1'b0;
    check("flush_full_fv", 64'(frame_valid), 64'd0);
    check("flush_full_ready", 64'(in_ready), 64'd1);
    check("flush_full_frame", 64'(frame_out), 64'h1555_5555);
`ifdef SHIFT3D_FRAME_PARITY_EN
    check("flush_full_parity", 64'(frame_parity), 64'd0);
`endif

    // asynchronous reset mid-frame
    for (int k = 0; k < 20; k++) send_bit(1'b1, 0);
    #2 reset = 1'b1;
    #1;
    check("async_in_ready", 64'(in_ready), 64'd0);
    check("async_fv", 64'(frame_valid), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_frame", 64'(frame_out), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    stream_frame(30'h0F0F_3C3C, 0);
    check("after_reset_fv", 64'(frame_valid), 64'd1);
    check("after_reset_frame", 64'(frame_out), 64'h0F0F_3C3C);
    take_frame(0);

    // random stalls on both handshakes, scoreboarded
    for (int f = 0; f < 50; f++) begin
      v = N'({$urandom, $urandom});
      exp_q.push_back(v);
      stream_frame(v, 2);
      check("rand_fv", 64'(frame_valid), 64'd1);
      got = exp_q.pop_front();
      check("rand_frame", 64'(frame_out), 64'(got));
`ifdef SHIFT3D_FRAME_PARITY_EN
      check("rand_parity", 64'(frame_parity), 64'(^got));
`endif
      take_frame(3);
      check("rand_fv_clear", 64'(frame_valid), 64'd0);
      check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
